rs_alu_scheduler: RTL and testbench

- Reservation-station scheduler that owns the integer ALU: it holds dispatched ALU ops and snoops both CDBs for pending operands.
- Each cycle it selects one ready entry and issues it to the ALU with the ALU's full/ready handshake.
- Sits between the dispatch stage, the CDBs (ALU and LSB broadcasts) and the ALU; flushed by the ROB's _clear.

---
 rtl/rs_alu_scheduler.sv | 164 ++++++++++++++++
 tb/tb_rs_alu_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu_scheduler.sv
// Reservation station for the integer ALU: holds dispatched ops, snoops the ALU
// and LSB result buses for pending operands, and issues one ready op per cycle.
module rs_alu_scheduler #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             _clear,
  input  logic             _dispatch_valid,
  input  logic [ROB_W-1:0] _dispatch_rob_id,
  input  logic [2:0]       _dispatch_op,
  input  logic             _dispatch_q1_busy,
  input  logic [ROB_W-1:0] _dispatch_q1,
  input  logic [31:0]      _dispatch_v1,
  input  logic             _dispatch_q2_busy,
  input  logic [ROB_W-1:0] _dispatch_q2,
  input  logic [31:0]      _dispatch_v2,
  output logic             _rs_full,
  input  logic             _cdb_alu_ready,
  input  logic [ROB_W-1:0] _cdb_alu_rob_id,
  input  logic [31:0]      _cdb_alu_value,
  input  logic             _cdb_lsb_ready,
  input  logic [ROB_W-1:0] _cdb_lsb_rob_id,
  input  logic [31:0]      _cdb_lsb_value,
  input  logic             _alu_full,
  output logic             _alu_ready,
  output logic [ROB_W-1:0] _alu_rob_id,
  output logic [2:0]       _alu_op,
  output logic [31:0]      _alu_v1,
  output logic [31:0]      _alu_v2
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] q1_busy;
  logic [DEPTH-1:0] q2_busy;
  logic [2:0]       op_q   [DEPTH];
  logic [ROB_W-1:0] rob_q  [DEPTH];
  logic [ROB_W-1:0] q1_tag [DEPTH];
  logic [ROB_W-1:0] q2_tag [DEPTH];
  logic [31:0]      v1_q   [DEPTH];
  logic [31:0]      v2_q   [DEPTH];

  logic [DEPTH-1:0] eligible;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [IDX_W-1:0] free_idx;
  logic             issue_en;
  logic             disp_en;
  logic             d_q1_busy;
  logic             d_q2_busy;
  logic [31:0]      d_v1;
  logic [31:0]      d_v2;

  assign _rs_full = &busy;
  assign eligible = busy & ~q1_busy & ~q2_busy;
  assign issue_en = rdy_in && !_alu_full && sel_any;
  assign disp_en  = rdy_in && _dispatch_valid && !_rs_full;

  // Fixed priority: scanning downward leaves the lowest index selected.
  always_comb begin
    sel_idx  = '0;
    sel_any  = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_idx = IDX_W'(i);
        sel_any = 1'b1;
      end
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  // A result broadcast in the dispatch cycle would otherwise be missed forever.
  always_comb begin
    d_q1_busy = _dispatch_q1_busy;
    d_v1      = _dispatch_v1;
    d_q2_busy = _dispatch_q2_busy;
    d_v2      = _dispatch_v2;
    if (_dispatch_q1_busy) begin
      if (_cdb_alu_ready && _cdb_alu_rob_id == _dispatch_q1) begin
        d_q1_busy = 1'b0;
        d_v1      = _cdb_alu_value;
      end else if (_cdb_lsb_ready && _cdb_lsb_rob_id == _dispatch_q1) begin
        d_q1_busy = 1'b0;
        d_v1      = _cdb_lsb_value;
      end
    end
    if (_dispatch_q2_busy) begin
      if (_cdb_alu_ready && _cdb_alu_rob_id == _dispatch_q2) begin
        d_q2_busy = 1'b0;
        d_v2      = _cdb_alu_value;
      end else if (_cdb_lsb_ready && _cdb_lsb_rob_id == _dispatch_q2) begin
        d_q2_busy = 1'b0;
        d_v2      = _cdb_lsb_value;
      end
    end
  end

  // Occupancy and issue outputs; issue data holds across a flush.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy        <= '0;
      _alu_ready  <= 1'b0;
      _alu_rob_id <= '0;
      _alu_op     <= '0;
      _alu_v1     <= '0;
      _alu_v2     <= '0;
    end else if (_clear) begin
      busy       <= '0;
      _alu_ready <= 1'b0;
    end else if (rdy_in) begin
      _alu_ready <= issue_en;
      if (issue_en) begin
        busy[sel_idx] <= 1'b0;
        _alu_rob_id   <= rob_q[sel_idx];
        _alu_op       <= op_q[sel_idx];
        _alu_v1       <= v1_q[sel_idx];
        _alu_v2       <= v2_q[sel_idx];
      end
      if (disp_en) busy[free_idx] <= 1'b1;
    end
  end

  // Entry payload needs no reset: it is only observed while the entry is busy.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !_clear && rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && q1_busy[i]) begin
          if (_cdb_alu_ready && _cdb_alu_rob_id == q1_tag[i]) begin
            q1_busy[i] <= 1'b0;
            v1_q[i]    <= _cdb_alu_value;
          end else if (_cdb_lsb_ready && _cdb_lsb_rob_id == q1_tag[i]) begin
            q1_busy[i] <= 1'b0;
            v1_q[i]    <= _cdb_lsb_value;
          end
        end
        if (busy[i] && q2_busy[i]) begin
          if (_cdb_alu_ready && _cdb_alu_rob_id == q2_tag[i]) begin
            q2_busy[i] <= 1'b0;
            v2_q[i]    <= _cdb_alu_value;
          end else if (_cdb_lsb_ready && _cdb_lsb_rob_id == q2_tag[i]) begin
            q2_busy[i] <= 1'b0;
            v2_q[i]    <= _cdb_lsb_value;
          end
        end
      end
      if (disp_en) begin
        op_q[free_idx]    <= _dispatch_op;
        rob_q[free_idx]   <= _dispatch_rob_id;
        q1_busy[free_idx] <= d_q1_busy;
        q1_tag[free_idx]  <= _dispatch_q1;
        v1_q[free_idx]    <= d_v1;
        q2_busy[free_idx] <= d_q2_busy;
        q2_tag[free_idx]  <= _dispatch_q2;
        v2_q[free_idx]    <= d_v2;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Bench for rs_alu_scheduler: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against an entry-list reference model.
module tb_rs_alu_scheduler;
  localparam int DEPTH = 8;
  localparam int ROB_W = 5;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, _clear;
  logic _dispatch_valid, _dispatch_q1_busy, _dispatch_q2_busy;
  logic [ROB_W-1:0] _dispatch_rob_id, _dispatch_q1, _dispatch_q2;
  logic [2:0] _dispatch_op;
  logic [31:0] _dispatch_v1, _dispatch_v2;
  logic _rs_full;
  logic _cdb_alu_ready, _cdb_lsb_ready;
  logic [ROB_W-1:0] _cdb_alu_rob_id, _cdb_lsb_rob_id;
  logic [31:0] _cdb_alu_value, _cdb_lsb_value;
  logic _alu_full, _alu_ready;
  logic [ROB_W-1:0] _alu_rob_id;
  logic [2:0] _alu_op;
  logic [31:0] _alu_v1, _alu_v2;

  int checks = 0;
  int failures = 0;

  rs_alu_scheduler #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._dispatch_valid(_dispatch_valid), ._dispatch_rob_id(_dispatch_rob_id),
    ._dispatch_op(_dispatch_op), ._dispatch_q1_busy(_dispatch_q1_busy),
    ._dispatch_q1(_dispatch_q1), ._dispatch_v1(_dispatch_v1),
    ._dispatch_q2_busy(_dispatch_q2_busy), ._dispatch_q2(_dispatch_q2),
    ._dispatch_v2(_dispatch_v2), ._rs_full(_rs_full),
    ._cdb_alu_ready(_cdb_alu_ready), ._cdb_alu_rob_id(_cdb_alu_rob_id),
    ._cdb_alu_value(_cdb_alu_value), ._cdb_lsb_ready(_cdb_lsb_ready),
    ._cdb_lsb_rob_id(_cdb_lsb_rob_id), ._cdb_lsb_value(_cdb_lsb_value),
    ._alu_full(_alu_full), ._alu_ready(_alu_ready), ._alu_rob_id(_alu_rob_id),
    ._alu_op(_alu_op), ._alu_v1(_alu_v1), ._alu_v2(_alu_v2)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of waiting ops plus the last issued op.
  typedef struct {
    bit busy; logic [2:0] op; logic [ROB_W-1:0] rob;
    bit p1; logic [ROB_W-1:0] t1; logic [31:0] v1;
    bit p2; logic [ROB_W-1:0] t2; logic [31:0] v2;
  } ent_t;
  ent_t m [DEPTH];
  bit m_valid = 0;
  bit e_ready;
  logic [ROB_W-1:0] e_rob;
  logic [2:0] e_op;
  logic [31:0] e_v1, e_v2;

  function automatic int occupancy();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) n++;
    return n;
  endfunction

  // Returns 1 and the broadcast value if a pending tag sees its result on a bus.
  function automatic bit snoop(input logic [ROB_W-1:0] tag, output logic [31:0] val);
    val = '0;
    if (_cdb_alu_ready && _cdb_alu_rob_id == tag) begin val = _cdb_alu_value; return 1; end
    if (_cdb_lsb_ready && _cdb_lsb_rob_id == tag) begin val = _cdb_lsb_value; return 1; end
    return 0;
  endfunction

  always @(posedge clk_in) begin
    int sel, fr, n;
    logic [31:0] val;
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
      e_ready = 0; e_rob = '0; e_op = '0; e_v1 = '0; e_v2 = '0;
      m_valid = 1;
    end else if (_clear) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
      e_ready = 0;
    end else if (rdy_in) begin
      sel = -1; fr = -1;
      n = occupancy();
      for (int i = 0; i < DEPTH; i++) begin
        if (sel < 0 && m[i].busy && !m[i].p1 && !m[i].p2) sel = i;
        if (fr < 0 && !m[i].busy) fr = i;
      end
      if (!_alu_full && sel >= 0) begin
        e_ready = 1; e_rob = m[sel].rob; e_op = m[sel].op;
        e_v1 = m[sel].v1; e_v2 = m[sel].v2;
        m[sel].busy = 0;
      end else begin
        e_ready = 0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].busy && m[i].p1 && snoop(m[i].t1, val)) begin m[i].p1 = 0; m[i].v1 = val; end
        if (m[i].busy && m[i].p2 && snoop(m[i].t2, val)) begin m[i].p2 = 0; m[i].v2 = val; end
      end
      if (_dispatch_valid && n < DEPTH) begin
        m[fr].busy = 1; m[fr].op = _dispatch_op; m[fr].rob = _dispatch_rob_id;
        m[fr].p1 = _dispatch_q1_busy; m[fr].t1 = _dispatch_q1; m[fr].v1 = _dispatch_v1;
        m[fr].p2 = _dispatch_q2_busy; m[fr].t2 = _dispatch_q2; m[fr].v2 = _dispatch_v2;
        if (m[fr].p1 && snoop(m[fr].t1, val)) begin m[fr].p1 = 0; m[fr].v1 = val; end
        if (m[fr].p2 && snoop(m[fr].t2, val)) begin m[fr].p2 = 0; m[fr].v2 = val; end
      end
    end
  end

  always @(negedge clk_in) begin
    if (m_valid) begin
      chk("model_alu_ready", 32'(_alu_ready), 32'(e_ready));
      chk("model_alu_rob_id", 32'(_alu_rob_id), 32'(e_rob));
      chk("model_alu_op", 32'(_alu_op), 32'(e_op));
      chk("model_alu_v1", _alu_v1, e_v1);
      chk("model_alu_v2", _alu_v2, e_v2);
      chk("model_rs_full", 32'(_rs_full), 32'(occupancy() == DEPTH));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; _clear = 0; _alu_full = 0;
    _dispatch_valid = 0; _dispatch_rob_id = '0; _dispatch_op = '0;
    _dispatch_q1_busy = 0; _dispatch_q1 = '0; _dispatch_v1 = '0;
    _dispatch_q2_busy = 0; _dispatch_q2 = '0; _dispatch_v2 = '0;
    _cdb_alu_ready = 0; _cdb_alu_rob_id = '0; _cdb_alu_value = '0;
    _cdb_lsb_ready = 0; _cdb_lsb_rob_id = '0; _cdb_lsb_value = '0;
  endtask

  task automatic disp(input int rob, input int op, input bit p1, input int t1,
                      input logic [31:0] v1, input bit p2, input int t2, input logic [31:0] v2);
    _dispatch_valid = 1; _dispatch_rob_id = ROB_W'(rob); _dispatch_op = 3'(op);
    _dispatch_q1_busy = p1; _dispatch_q1 = ROB_W'(t1); _dispatch_v1 = v1;
    _dispatch_q2_busy = p2; _dispatch_q2 = ROB_W'(t2); _dispatch_v2 = v2;
  endtask

  task automatic expect_issue(input string name, input int rob, input logic [31:0] v1);
    chk({name, "_ready"}, 32'(_alu_ready), 32'd1);
    chk({name, "_rob"}, 32'(_alu_rob_id), 32'(rob));
    chk({name, "_v1"}, _alu_v1, v1);
  endtask

  initial begin
    logic [ROB_W-1:0] t;
    idle();
    rst_in = 1;
    disp(3, 2, 0, 0, 32'd5, 0, 0, 32'd7);
    tick(); tick();
    chk("reset_alu_ready", 32'(_alu_ready), 32'd0);
    chk("reset_alu_v1", _alu_v1, 32'd0);
    chk("reset_rs_full", 32'(_rs_full), 32'd0);
    idle();
    tick(); tick();
    chk("reset_no_issue", 32'(_alu_ready), 32'd0);

    // Ready op: dispatch edge N, strobe after edge N+1, one cycle wide.
    disp(3, 2, 0, 0, 32'd5, 0, 0, 32'd7);
    tick();
    _dispatch_valid = 0;
    chk("ready_not_yet", 32'(_alu_ready), 32'd0);
    tick();
    expect_issue("ready_op", 3, 32'd5);
    chk("ready_op_op", 32'(_alu_op), 32'd2);
    chk("ready_op_v2", _alu_v2, 32'd7);
    tick();
    chk("ready_pulse_end", 32'(_alu_ready), 32'd0);

    // Wakeup from a later ALU broadcast.
    disp(4, 1, 1, 9, 32'd0, 0, 0, 32'd1);
    tick();
    idle();
    _cdb_alu_ready = 1; _cdb_alu_rob_id = 5'd9; _cdb_alu_value = 32'h1234;
    tick();
    idle();
    chk("wake_not_yet", 32'(_alu_ready), 32'd0);
    tick();
    expect_issue("wake_alu", 4, 32'h1234);

    // Broadcast in the dispatch cycle itself is captured directly.
    disp(5, 1, 1, 9, 32'd0, 0, 0, 32'd1);
    _cdb_alu_ready = 1; _cdb_alu_rob_id = 5'd9; _cdb_alu_value = 32'h55;
    tick();
    idle();
    tick();
    expect_issue("wake_same_cycle", 5, 32'h55);
    tick();

    // Fill all entries, refuse a ninth, then drain in index order.
    for (int i = 0; i < DEPTH; i++) begin
      disp(10 + i, 3, 1, 1, 32'd0, 0, 0, 32'(i));
      tick();
    end
    chk("fill_full", 32'(_rs_full), 32'd1);
    disp(20, 3, 0, 0, 32'h99, 0, 0, 32'h99);
    tick();
    chk("fill_refused_full", 32'(_rs_full), 32'd1);
    chk("fill_no_issue", 32'(_alu_ready), 32'd0);
    idle();
    _cdb_lsb_ready = 1; _cdb_lsb_rob_id = 5'd1; _cdb_lsb_value = 32'h77;
    tick();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      expect_issue("fill_drain", 10 + i, 32'h77);
      if (i == 0) chk("fill_full_drops", 32'(_rs_full), 32'd0);
    end
    tick();
    chk("fill_ninth_lost", 32'(_alu_ready), 32'd0);

    // Backpressure holds three ready ops, then they leave lowest index first.
    _alu_full = 1;
    for (int i = 0; i < 3; i++) begin
      disp(21 + i, 4, 0, 0, 32'(100 + i), 0, 0, 32'd0);
      tick();
    end
    _dispatch_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("backpressure_hold", 32'(_alu_ready), 32'd0);
    end
    _alu_full = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_issue("backpressure_release", 21 + i, 32'(100 + i));
    end
    tick();
    chk("backpressure_done", 32'(_alu_ready), 32'd0);

    // Flush with four busy entries leaves nothing to issue.
    _alu_full = 1;
    for (int i = 0; i < 4; i++) begin
      disp(24 + i, 5, 0, 0, 32'd1, 0, 0, 32'd2);
      tick();
    end
    idle();
    _alu_full = 1; _clear = 1;
    tick();
    chk("flush_ready", 32'(_alu_ready), 32'd0);
    chk("flush_rs_full", 32'(_rs_full), 32'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_stale", 32'(_alu_ready), 32'd0);
    end

    // Freeze in the middle of a strobe.
    disp(30, 6, 0, 0, 32'hAA, 0, 0, 32'hBB);
    tick();
    _dispatch_valid = 0;
    tick();
    expect_issue("freeze_pre", 30, 32'hAA);
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_issue("freeze_hold", 30, 32'hAA);
      chk("freeze_hold_v2", _alu_v2, 32'hBB);
    end
    rdy_in = 1;
    tick();
    chk("freeze_release", 32'(_alu_ready), 32'd0);

    // Random traffic against the model; small tag space forces matches.
    for (int c = 0; c < 3000; c++) begin
      rst_in = ($urandom_range(0, 399) == 0);
      _clear = ($urandom_range(0, 99) == 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      _alu_full = ($urandom_range(0, 3) == 0);
      _dispatch_valid = $urandom_range(0, 1);
      _dispatch_rob_id = ROB_W'($urandom);
      _dispatch_op = 3'($urandom);
      _dispatch_q1_busy = ($urandom_range(0, 9) < 4);
      _dispatch_q1 = ROB_W'($urandom_range(0, 3));
      _dispatch_v1 = $urandom;
      _dispatch_q2_busy = ($urandom_range(0, 9) < 4);
      _dispatch_q2 = ROB_W'($urandom_range(0, 3));
      _dispatch_v2 = $urandom;
      t = ROB_W'($urandom_range(0, 3));
      _cdb_alu_ready = ($urandom_range(0, 2) == 0);
      _cdb_alu_rob_id = t;
      _cdb_alu_value = $urandom;
      _cdb_lsb_ready = ($urandom_range(0, 2) == 0);
      _cdb_lsb_rob_id = ROB_W'((t + ROB_W'($urandom_range(1, 3))) % 4);
      _cdb_lsb_value = $urandom;
      tick();
    end

    idle();
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
